// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer controller.
// Holds the register map, CR field offsets, the sequencer state type,
// the interrupt-status layout and the CR reset value.
package spi_pkg;

    // Register addresses on the APB-side register port
    localparam logic [2:0] ADDR_CR   = 3'd0;
    localparam logic [2:0] ADDR_BR   = 3'd1;
    localparam logic [2:0] ADDR_INTE = 3'd2;
    localparam logic [2:0] ADDR_SR   = 3'd3;
    localparam logic [2:0] ADDR_RINT = 3'd4;
    localparam logic [2:0] ADDR_INT  = 3'd5;

    // CR field bit offsets
    localparam int CR_SPIE    = 0;
    localparam int CR_MSTR    = 1;
    localparam int CR_CPOL    = 2;
    localparam int CR_CPHA    = 3;
    localparam int CR_DORD    = 4;
    localparam int CR_SWR     = 5;
    localparam int CR_CSHOLD  = 6;
    localparam int CR_CSSEL   = 8;
    localparam int CR_DATALEN = 16;
    localparam int CR_TXDL    = 24;

    // Enabled, 8-bit frames, no inter-frame delay
    localparam logic [31:0] CR_RESET = 32'h0007_0001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DELAY = 2'd3
    } fsm_e;

    // Bit order matches the {rx_flags, tx_flags} concatenation
    typedef struct packed {
        logic rx_udf;
        logic rx_ovf;
        logic rx_full;
        logic rx_empty;
        logic tx_udf;
        logic tx_ovf;
        logic tx_full;
        logic tx_empty;
    } rint_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for a single level signal coming from the
// shift-clock domain.
// Ports: clk, rst_n (async, active-low), d (async input), q (synchronised).
module spi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI control/register core: register file (CR/BR/INTE/SR/RINT/INT),
// frame sequencer with 4-phase request/ack to the shifter, inter-frame
// delay counter, chip-select generation and sticky W1C interrupts.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   wr_en/wr_addr/wr_data          register write port
//   rd_addr/rd_data                combinational register read port
//   tx_flags/rx_flags              FIFO flags {udf,ovf,full,empty}
//   tx_level/rx_level              FIFO fill levels
//   xfer_req/xfer_ack/xfer_done    shifter handshake (ack/done async)
//   cfg_*                          frame configuration latched per frame
//   cs_n                           active-low chip selects
//   tx_pop/rx_push/fifo_clr        FIFO control pulses
//   irq                            OR of enabled pending interrupts
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int PTR_W       = 4,
    parameter int NUM_CS      = 4,
    parameter int LEN_W       = 5,
    parameter int DLY_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [2:0]        rd_addr,
    output logic [31:0]       rd_data,
    input  logic [3:0]        tx_flags,
    input  logic [3:0]        rx_flags,
    input  logic [PTR_W:0]    tx_level,
    input  logic [PTR_W:0]    rx_level,
    output logic              xfer_req,
    input  logic              xfer_ack,
    input  logic              xfer_done,
    output logic              cfg_mstr,
    output logic              cfg_cpol,
    output logic              cfg_cpha,
    output logic              cfg_dord,
    output logic [LEN_W-1:0]  cfg_len,
    output logic [7:0]        cfg_br,
    output logic [NUM_CS-1:0] cs_n,
    output logic              tx_pop,
    output logic              rx_push,
    output logic              fifo_clr,
    output logic              irq
);

    // Storable CR bits; SWR is excluded so it always reads back 0
    localparam logic [31:0] CR_MASK = 32'h0000_0F5F
        | ({{(32-LEN_W){1'b0}}, {LEN_W{1'b1}}} << CR_DATALEN)
        | ({{(32-DLY_W){1'b0}}, {DLY_W{1'b1}}} << CR_TXDL);

    logic [31:0]      cr_q;
    logic [7:0]       br_q;
    logic [7:0]       inte_q;
    logic [31:0]      sr_q;
    logic [31:0]      sr_next;
    rint_t            rint_q;
    rint_t            rint_set;
    logic [7:0]       rint_w1c;
    logic [7:0]       int_vec;
    logic             swr_q;

    fsm_e             state_q;
    fsm_e             state_d;
    logic [DLY_W-1:0] cnt_q;
    logic [DLY_W-1:0] cnt_d;
    logic             latch_cfg;
    logic             ack_low_q;
    logic             hold_q;
    logic             cs_active;

    logic             ack_s;
    logic             done_s;
    logic             done_s_d;
    logic             done_rise;

    logic             spie;
    logic             cshold;
    logic [3:0]       cssel;
    logic [DLY_W-1:0] txdl;
    logic             wr_cr;
    logic             swr_hit;
    logic             abort;

    assign spie    = cr_q[CR_SPIE];
    assign cshold  = cr_q[CR_CSHOLD];
    assign cssel   = cr_q[CR_CSSEL +: 4];
    assign txdl    = cr_q[CR_TXDL +: DLY_W];
    assign wr_cr   = wr_en && (wr_addr == ADDR_CR);
    assign swr_hit = wr_cr && wr_data[CR_SWR];
    // Any of these kills an in-flight frame and parks the sequencer
    assign abort   = !spie || swr_hit || swr_q;

    // Status snapshot of both FIFO levels
    always_comb begin
        sr_next = '0;
        sr_next[16 +: PTR_W+1] = rx_level;
        sr_next[0  +: PTR_W+1] = tx_level;
    end

    // CR is always writable; BR/INTE only while the core is enabled.
    // SWR is held one cycle to drive the FIFO clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cr_q   <= CR_RESET & CR_MASK;
            br_q   <= '0;
            inte_q <= '0;
            sr_q   <= '0;
            swr_q  <= 1'b0;
        end else begin
            swr_q <= swr_hit;
            sr_q  <= sr_next;
            if (wr_cr) begin
                cr_q <= wr_data & CR_MASK;
            end
            if (wr_en && spie && (wr_addr == ADDR_BR)) begin
                br_q <= wr_data[7:0];
            end
            if (wr_en && spie && (wr_addr == ADDR_INTE)) begin
                inte_q <= wr_data[7:0];
            end
        end
    end

    // Sticky interrupt status; a flag raised in the same cycle as a W1C wins
    assign rint_set = rint_t'({rx_flags, tx_flags});
    assign rint_w1c = (wr_en && (wr_addr == ADDR_RINT)) ? wr_data[7:0] : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rint_q <= '0;
        end else if (!spie || swr_hit) begin
            rint_q <= '0;
        end else begin
            rint_q <= rint_t'((rint_q & ~rint_w1c) | rint_set);
        end
    end

    assign int_vec = rint_q & inte_q;
    assign irq     = |int_vec;

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            ADDR_CR:   rd_data = cr_q;
            ADDR_BR:   rd_data = {24'h0, br_q};
            ADDR_INTE: rd_data = {24'h0, inte_q};
            ADDR_SR:   rd_data = sr_q;
            ADDR_RINT: rd_data = {24'h0, rint_q};
            ADDR_INT:  rd_data = {24'h0, int_vec};
            default:   rd_data = '0;
        endcase
    end

    spi_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (xfer_ack),
        .q     (ack_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES)) u_done_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (xfer_done),
        .q     (done_s)
    );

    assign done_rise = done_s && !done_s_d;

    // Sequencer next-state, delay counter and handshake/FIFO strobes
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch_cfg = 1'b0;
        xfer_req  = 1'b0;
        tx_pop    = 1'b0;
        rx_push   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!tx_flags[0]) begin
                    latch_cfg = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                xfer_req = 1'b1;
                // A stale ack from the previous frame must drop first
                if (ack_s && ack_low_q) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (done_rise) begin
                    tx_pop  = 1'b1;
                    rx_push = 1'b1;
                    state_d = DELAY;
                end
            end
            DELAY: begin
                if (cnt_q == txdl) begin
                    cnt_d = '0;
                    if (!tx_flags[0]) begin
                        latch_cfg = 1'b1;
                        state_d   = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d   = IDLE;
            cnt_d     = '0;
            latch_cfg = 1'b0;
            xfer_req  = 1'b0;
            tx_pop    = 1'b0;
            rx_push   = 1'b0;
        end
    end

    // Sequencer state, ack-low tracking, CS hold and per-frame config
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ack_low_q <= 1'b0;
            hold_q    <= 1'b0;
            done_s_d  <= 1'b0;
            cfg_mstr  <= CR_RESET[CR_MSTR];
            cfg_cpol  <= CR_RESET[CR_CPOL];
            cfg_cpha  <= CR_RESET[CR_CPHA];
            cfg_dord  <= CR_RESET[CR_DORD];
            cfg_len   <= CR_RESET[CR_DATALEN +: LEN_W];
            cfg_br    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_s_d <= done_s;
            if (state_q != REQ) begin
                ack_low_q <= 1'b0;
            end else if (!ack_s) begin
                ack_low_q <= 1'b1;
            end
            if (abort) begin
                hold_q <= 1'b0;
            end else if (state_q == REQ) begin
                hold_q <= 1'b1;
            end
            if (latch_cfg) begin
                cfg_mstr <= cr_q[CR_MSTR];
                cfg_cpol <= cr_q[CR_CPOL];
                cfg_cpha <= cr_q[CR_CPHA];
                cfg_dord <= cr_q[CR_DORD];
                cfg_len  <= cr_q[CR_DATALEN +: LEN_W];
                cfg_br   <= br_q;
            end
        end
    end

    // Chip select: out-of-range CSSEL simply matches no line
    always_comb begin
        cs_active = 1'b0;
        if (spie && cr_q[CR_MSTR]) begin
            case (state_q)
                REQ, WAIT: cs_active = 1'b1;
                DELAY:     cs_active = cshold;
                IDLE:      cs_active = cshold && hold_q;
                default:   cs_active = 1'b0;
            endcase
        end
        cs_n = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (cs_active && (cssel == 4'(i))) begin
                cs_n[i] = 1'b0;
            end
        end
    end

    assign fifo_clr = swr_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed self-checking bench for spi_xfer_ctrl: reset values, single and
// back-to-back frames with inter-frame delay, sticky W1C interrupts,
// soft reset mid-frame and config latching across a CR rewrite.
module tb_spi_xfer_ctrl;

    localparam int PTR_W  = 4;
    localparam int NUM_CS = 4;
    localparam int LEN_W  = 5;
    localparam int DLY_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [2:0]        wr_addr;
    logic [31:0]       wr_data;
    logic [2:0]        rd_addr;
    logic [31:0]       rd_data;
    logic [3:0]        tx_flags;
    logic [3:0]        rx_flags;
    logic [PTR_W:0]    tx_level;
    logic [PTR_W:0]    rx_level;
    logic              xfer_req;
    logic              xfer_ack;
    logic              xfer_done;
    logic              cfg_mstr;
    logic              cfg_cpol;
    logic              cfg_cpha;
    logic              cfg_dord;
    logic [LEN_W-1:0]  cfg_len;
    logic [7:0]        cfg_br;
    logic [NUM_CS-1:0] cs_n;
    logic              tx_pop;
    logic              rx_push;
    logic              fifo_clr;
    logic              irq;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    spi_xfer_ctrl #(
        .PTR_W(PTR_W), .NUM_CS(NUM_CS), .LEN_W(LEN_W), .DLY_W(DLY_W), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .tx_flags(tx_flags), .rx_flags(rx_flags),
        .tx_level(tx_level), .rx_level(rx_level),
        .xfer_req(xfer_req), .xfer_ack(xfer_ack), .xfer_done(xfer_done),
        .cfg_mstr(cfg_mstr), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
        .cfg_dord(cfg_dord), .cfg_len(cfg_len), .cfg_br(cfg_br),
        .cs_n(cs_n), .tx_pop(tx_pop), .rx_push(rx_push),
        .fifo_clr(fifo_clr), .irq(irq)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One-cycle register write, issued from a falling edge
    task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(negedge clk);
        wr_en   = 1'b0;
        wr_data = '0;
    endtask

    task automatic readReg(input logic [2:0] addr, output logic [31:0] data);
        rd_addr = addr;
        #1;
        data = rd_data;
    endtask

    task automatic waitReq(input string tag);
        int n = 0;
        while (!xfer_req && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, {31'b0, xfer_req}, 32'd1);
    endtask

    // Shifter model for one frame; entered with xfer_req high,
    // returns on the falling edge where tx_pop is seen
    task automatic runFrame(input string tag, input logic set_empty);
        int n = 0;
        xfer_ack = 1'b1;
        while (xfer_req && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_req_drop"}, {31'b0, xfer_req}, 32'd0);
        checkOutput({tag, "_cs_wait"}, {28'b0, cs_n}, 32'hB);
        xfer_ack  = 1'b0;
        xfer_done = 1'b1;
        n = 0;
        while (!tx_pop && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_pop"}, {31'b0, tx_pop}, 32'd1);
        checkOutput({tag, "_push"}, {31'b0, rx_push}, 32'd1);
        xfer_done = 1'b0;
        if (set_empty) tx_flags = 4'b0001;
    endtask

    // Falling edges from the pop until the next request
    task automatic measureGap(output int gap);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!xfer_req && gap < 40);
    endtask

    initial begin
        logic [31:0] rdv;
        int          gap;
        logic        seen;

        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr   = '0;
        tx_flags  = 4'b0001;
        rx_flags  = 4'b0000;
        tx_level  = '0;
        rx_level  = '0;
        xfer_ack  = 1'b0;
        xfer_done = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        readReg(3'd0, rdv);
        checkOutput("reset_cr", rdv, 32'h0007_0001);
        for (int a = 1; a <= 5; a++) begin
            readReg(3'(a), rdv);
            checkOutput($sformatf("reset_rd%0d", a), rdv, 32'h0);
        end
        checkOutput("reset_cs", {28'b0, cs_n}, 32'hF);
        checkOutput("reset_req", {31'b0, xfer_req}, 32'd0);
        checkOutput("reset_irq", {31'b0, irq}, 32'd0);
        checkOutput("reset_len", {27'b0, cfg_len}, 32'd7);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-slave frames, CSSEL=2, TXDL=0
        applyStimulus(3'd0, 32'h0007_0203);
        tx_flags = 4'b0000;
        waitReq("t2_req");
        checkOutput("t2_cs_req", {28'b0, cs_n}, 32'hB);
        checkOutput("t2_cfg_mstr", {31'b0, cfg_mstr}, 32'd1);
        checkOutput("t2_cfg_len", {27'b0, cfg_len}, 32'd7);
        runFrame("t2_f1", 1'b0);
        measureGap(gap);
        checkOutput("t2_gap_txdl0", 32'(gap), 32'd2);
        runFrame("t2_f2", 1'b1);
        @(negedge clk);
        checkOutput("t2_pop_1cyc", {31'b0, tx_pop}, 32'd0);
        checkOutput("t2_push_1cyc", {31'b0, rx_push}, 32'd0);
        checkOutput("t2_cs_delay", {28'b0, cs_n}, 32'hF);
        @(negedge clk);
        checkOutput("t2_idle_req", {31'b0, xfer_req}, 32'd0);

        // Three frames with TXDL=5 and a new baud divisor
        applyStimulus(3'd1, 32'h0000_0012);
        applyStimulus(3'd0, 32'h0507_0203);
        tx_flags = 4'b0000;
        waitReq("t3_req");
        checkOutput("t3_cfg_br", {24'b0, cfg_br}, 32'h12);
        runFrame("t3_f1", 1'b0);
        measureGap(gap);
        checkOutput("t3_gap1", 32'(gap), 32'd7);
        runFrame("t3_f2", 1'b0);
        measureGap(gap);
        checkOutput("t3_gap2", 32'(gap), 32'd7);
        runFrame("t3_f3", 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (xfer_req) seen = 1'b1;
        end
        checkOutput("t3_idle_after3", {31'b0, seen}, 32'd0);
        checkOutput("t3_cs_idle", {28'b0, cs_n}, 32'hF);

        // Status register snapshot
        tx_level = 5'd3;
        rx_level = 5'd9;
        @(negedge clk);
        readReg(3'd3, rdv);
        checkOutput("sr_levels", rdv, 32'h0009_0003);

        // Sticky rx_ovf interrupt with W1C
        applyStimulus(3'd2, 32'h0000_0040);
        rx_flags = 4'b0100;
        @(negedge clk);
        rx_flags = 4'b0000;
        @(negedge clk);
        readReg(3'd4, rdv);
        checkOutput("rint_ovf", rdv, 32'h41);
        readReg(3'd5, rdv);
        checkOutput("int_ovf", rdv, 32'h40);
        checkOutput("irq_ovf", {31'b0, irq}, 32'd1);
        rx_flags = 4'b0100;
        applyStimulus(3'd4, 32'h0000_0040);
        rx_flags = 4'b0000;
        readReg(3'd5, rdv);
        checkOutput("int_set_wins", rdv, 32'h40);
        checkOutput("irq_set_wins", {31'b0, irq}, 32'd1);
        applyStimulus(3'd4, 32'h0000_0040);
        readReg(3'd4, rdv);
        checkOutput("rint_w1c", rdv, 32'h01);
        checkOutput("irq_w1c", {31'b0, irq}, 32'd0);

        // Soft reset while waiting for done
        tx_flags = 4'b0000;
        waitReq("t5_req");
        xfer_ack = 1'b1;
        for (int i = 0; i < 30 && xfer_req; i++) @(negedge clk);
        checkOutput("t5_in_wait", {31'b0, xfer_req}, 32'd0);
        checkOutput("t5_cs_wait", {28'b0, cs_n}, 32'hB);
        applyStimulus(3'd0, 32'h0507_0223);
        checkOutput("t5_fifo_clr", {31'b0, fifo_clr}, 32'd1);
        checkOutput("t5_cs_swr", {28'b0, cs_n}, 32'hF);
        checkOutput("t5_req_swr", {31'b0, xfer_req}, 32'd0);
        readReg(3'd4, rdv);
        checkOutput("t5_rint_clr", rdv, 32'h0);
        tx_flags = 4'b0001;
        @(negedge clk);
        checkOutput("t5_fifo_clr_1cyc", {31'b0, fifo_clr}, 32'd0);
        readReg(3'd0, rdv);
        checkOutput("t5_swr_reads0", rdv, 32'h0507_0203);
        xfer_ack  = 1'b0;
        xfer_done = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_pop) seen = 1'b1;
            if (i == 4) xfer_done = 1'b0;
        end
        checkOutput("t5_late_done_nopop", {31'b0, seen}, 32'd0);

        // DATALEN rewrite mid-frame applies only from the next frame
        tx_flags = 4'b0000;
        waitReq("t6_req");
        checkOutput("t6_len_first", {27'b0, cfg_len}, 32'd7);
        xfer_ack = 1'b1;
        for (int i = 0; i < 30 && xfer_req; i++) @(negedge clk);
        applyStimulus(3'd0, 32'h050F_0203);
        checkOutput("t6_len_midframe", {27'b0, cfg_len}, 32'd7);
        xfer_ack  = 1'b0;
        xfer_done = 1'b1;
        for (int i = 0; i < 30 && !tx_pop; i++) @(negedge clk);
        checkOutput("t6_pop", {31'b0, tx_pop}, 32'd1);
        xfer_done = 1'b0;
        @(negedge clk);
        checkOutput("t6_len_delay", {27'b0, cfg_len}, 32'd7);
        waitReq("t6_req2");
        checkOutput("t6_len_next", {27'b0, cfg_len}, 32'd15);
        runFrame("t6_f2", 1'b1);
        repeat (10) @(negedge clk);

        // Disabled core ignores BR writes and deasserts chip selects
        applyStimulus(3'd0, 32'h0000_0202);
        applyStimulus(3'd1, 32'h0000_0034);
        readReg(3'd1, rdv);
        checkOutput("spie0_br_locked", rdv, 32'h12);
        readReg(3'd4, rdv);
        checkOutput("spie0_rint_held", rdv, 32'h0);
        checkOutput("spie0_cs", {28'b0, cs_n}, 32'hF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
